sub_bytes_seq: RTL and testbench
================================

// Module: sub_bytes_seq
// PURPOSE
//  Byte-serial AES SubBytes/InvSubBytes engine. Feeds ShiftRows directly: its Data_out is
//  wired to the ShiftRows Data_in.
//  Substitutes LANES state bytes per cycle through LANES S-box instances, trading latency for area.
//  Uses a valid/ready handshake on both sides so the round controller can stall it.
//  State layout: [0:127], byte k at bits [8k+:8] (row k%4, column k/4), matching ShiftRows.
// PARAMETERS
//  LANES  4  S-box lookups per cycle; legal values 1, 2, 4, 8, 16; latency = 16/LANES cycles
// PORTS
//  clk         in   1    single clock, rising edge
//  rst         in   1    reset, asynchronous, active-high
//  in_valid    in   1    Data_in/inv_mode valid
//  in_ready    out  1    engine can accept a new state
//  Data_in     in   128  [0:127] state to substitute
//  inv_mode    in   1    0 = forward S-box, 1 = inverse S-box; sampled on accept
//  out_valid   out  1    Data_out holds a completed result
//  out_ready   in   1    downstream accepts Data_out
//  Data_out    out  128  [0:127] substituted state, to ShiftRows
// BEHAVIOUR
//  Reset (async, rst=1): state IDLE, cnt=0, result reg=0, inv reg=0; Data_out=0, out_valid=0.
//   in_ready=1 as soon as rst deasserts. An in-flight block is discarded without any output.
//  FSM states: IDLE, BUSY, DONE. in_ready = (state==IDLE); out_valid = (state==DONE).
//  IDLE: when in_valid=1, on the clock edge: capture Data_in into the src reg, capture inv_mode,
//   set cnt=0, go to BUSY. in_valid=0 stays in IDLE.
//  BUSY: each cycle, result bytes [cnt*LANES .. cnt*LANES+LANES-1] <= S/InvS(src bytes, same index).
//   Increment cnt. When cnt == 16/LANES-1, perform the last write and go to DONE.
//  DONE: Data_out = result reg, held stable while out_ready=0. out_valid=1 with out_ready=1:
//   handshake on that edge, go to IDLE.
//  Latency: accept at edge N gives out_valid=1 after edge N+16/LANES (LANES=4: 4 cycles).
//   Throughput: one block per 16/LANES+2 cycles.
//  No accept in DONE or BUSY. Data_in/inv_mode changes after accept have no effect.
//  LANES=16: BUSY lasts exactly one cycle. cnt is $clog2(16/LANES) bits wide, minimum 1 bit.
//   cnt never exceeds 16/LANES-1.
//  S-box/InvS-box: the FIPS-197 tables, combinational, one per lane.
//   Inverse is selected by the captured inv reg, not the live port.
//  Data_out bytes not yet written in BUSY keep their old value and are not observable (out_valid=0).
//  Illegal LANES: elaboration error via generate-time check.
// TESTING
//  1 Reset: rst pulse mid-clock -> immediately out_valid=0, Data_out=0; in_ready=1 after release.
//  2 Fwd: Data_in=128'h00112233445566778899aabbccddeeff, inv=0 ->
//    Data_out=128'h638293c31bfc33f5c4eeacea4bc12816, 4 cycles after accept (LANES=4).
//  3 Inv: Data_in=all 128'h0, inv=1 -> Data_out=all 8'h52. Then feed that result back with inv=0
//    -> all 8'h00.
//  4 Backpressure: hold out_ready=0 for 10 cycles in DONE -> Data_out stable, in_ready=0.
//    Assert out_ready=1 -> 1-cycle handshake, then IDLE.
//  5 Reset mid-op: assert rst in 2nd BUSY cycle -> no out_valid. Next block (all 8'hff, inv=0)
//    -> all 8'h16.
//  6 Param sweep LANES=1,2,8,16 with vector 2 -> same result, latency 16/8/2/1 cycles.
//    Back-to-back in_valid=1 -> accepts exactly 1 per 16/LANES+2 cycles.

Source files
------------

// File: rtl/sub_bytes_seq.sv
// Byte-serial AES SubBytes/InvSubBytes engine: LANES S-box lookups per cycle,
// valid/ready on both sides. State layout [0:127], byte k at [8k+:8].

module sub_bytes_lane (
  input  logic [7:0] din,
  input  logic       inv,
  output logic [7:0] dout
);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  localparam logic [2047:0] ISBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  logic [10:0] idx;

  // Entry 0 sits in the MSBs of the packed tables, so entry b starts at 8*(255-b).
  assign idx  = {~din, 3'b000};
  assign dout = inv ? ISBOX[idx +: 8] : SBOX[idx +: 8];
endmodule

module sub_bytes_seq #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] Data_in,
  input  logic         inv_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] Data_out
);
  localparam int STEPS = 16 / LANES;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int CHUNK = 8 * LANES;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [0:127]     src;
  logic [0:127]     res;
  logic             inv;
  logic [7:0]       base;
  logic [0:CHUNK-1] win;
  logic [0:CHUNK-1] sub;

  assign base     = 8'(cnt) * 8'(CHUNK);
  assign win      = src[base +: CHUNK];
  assign Data_out = res;

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    sub_bytes_lane u_lane (
      .din  (win[8*j +: 8]),
      .inv  (inv),
      .dout (sub[8*j +: 8])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      src       <= '0;
      res       <= '0;
      inv       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          src      <= Data_in;
          inv      <= inv_mode;
          cnt      <= '0;
          in_ready <= 1'b0;
          state    <= BUSY;
        end
        BUSY: begin
          res[base +: CHUNK] <= sub;
          if (cnt == LAST) begin
            cnt       <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sub_bytes_seq.sv
// Bench for sub_bytes_seq: one instance per legal LANES, GF(2^8)-derived S-box model.
`timescale 1ns/1ps

module tb_sub_bytes_seq;
  localparam int M = 2;   // instance with LANES=4

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic [0:127]   Data_in = '0;
  logic           inv_mode = 1'b0;
  logic           out_ready = 1'b0;
  logic [4:0]        rdy, ov;
  logic [4:0][127:0] dq;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb  [256];
  logic [7:0] isb [256];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    sub_bytes_seq #(.LANES(1 << g)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (rdy[g]),
      .Data_in   (Data_in),
      .inv_mode  (inv_mode),
      .out_valid (ov[g]),
      .out_ready (out_ready),
      .Data_out  (dq[g])
    );
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  task automatic build_tables();
    logic [7:0] b, s;
    for (int a = 0; a < 256; a++) begin
      b = 8'h00;
      for (int x = 1; x < 256; x++)
        if (a != 0 && gmul(8'(a), 8'(x)) == 8'h01) b = 8'(x);
      s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
      sb[a]  = s;
      isb[s] = 8'(a);
    end
  endtask

  function automatic logic [0:127] model(input logic [0:127] d, input logic iv);
    logic [0:127] r;
    for (int k = 0; k < 16; k++)
      r[8*k +: 8] = iv ? isb[d[8*k +: 8]] : sb[d[8*k +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called at posedge+1 with the LANES=4 instance idle; returns at posedge+1, idle again.
  task automatic run_block(input logic [127:0] d, input logic iv, input int stall,
                           output logic [127:0] got);
    int lat;
    logic [127:0] exp;
    exp = model(d, iv);
    chk("idle_before", rdy[M], 1'b1);
    in_valid = 1'b1; Data_in = d; inv_mode = iv;
    @(posedge clk); #1;
    in_valid = 1'b0; Data_in = rnd128(); inv_mode = ~iv;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (ov[M]) break;
    end
    chk("latency", lat, 4);
    got = dq[M];
    chk("data", got, exp);
    in_valid = 1'b1;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("bp_data", dq[M], got);
      chk("bp_flags", {ov[M], rdy[M]}, 2'b10);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("hs_idle", {ov[M], rdy[M]}, 2'b01);
  endtask

  initial begin
    logic [127:0] got, v2, exp2;
    int hits;
    int lat [5];
    int acc [5];

    build_tables();
    v2   = 128'h00112233445566778899aabbccddeeff;
    exp2 = 128'h638293c31bfc33f5c4eeacea4bc12816;

    #3;
    chk("rst_ov", ov[M], 1'b0);
    chk("rst_dout", dq[M], '0);
    @(negedge clk) rst = 1'b0;
    #1 chk("rst_rdy", rdy[M], 1'b1);
    @(posedge clk); #1;

    run_block(v2, 1'b0, 0, got);
    chk("fwd_vec", got, exp2);

    run_block('0, 1'b1, 0, got);
    chk("inv_zero", got, {16{8'h52}});
    run_block(got, 1'b0, 0, got);
    chk("fwd_back", got, '0);

    run_block(rnd128(), 1'b1, 10, got);

    // Async reset in the second BUSY cycle discards the block.
    in_valid = 1'b1; Data_in = rnd128(); inv_mode = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("midrst_ov", ov[M], 1'b0);
    chk("midrst_dout", dq[M], '0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    hits = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (ov[M]) hits++;
    end
    chk("midrst_no_out", hits, 0);
    run_block({16{8'hff}}, 1'b0, 0, got);
    chk("ff_vec", got, {16{8'h16}});

    for (int n = 0; n < 20; n++)
      run_block(rnd128(), 1'($urandom_range(0, 1)), $urandom_range(0, 3), got);

    // Latency sweep across every LANES instance.
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    for (int g = 0; g < 5; g++) lat[g] = 0;
    in_valid = 1'b1; Data_in = v2; inv_mode = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; Data_in = rnd128(); inv_mode = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      for (int g = 0; g < 5; g++)
        if (ov[g] && lat[g] == 0) lat[g] = c;
    end
    for (int g = 0; g < 5; g++) begin
      chk($sformatf("sweep_lat_L%0d", 1 << g), lat[g], 16 >> g);
      chk($sformatf("sweep_data_L%0d", 1 << g), dq[g], exp2);
    end

    // Back-to-back requests with a free-running consumer.
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    for (int g = 0; g < 5; g++) acc[g] = 0;
    in_valid = 1'b1; out_ready = 1'b1;
    repeat (60) begin
      @(negedge clk);
      for (int g = 0; g < 5; g++)
        if (rdy[g]) acc[g]++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    for (int g = 0; g < 5; g++)
      chk($sformatf("thru_L%0d", 1 << g), acc[g], (60 + (16 >> g) + 1) / ((16 >> g) + 2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
